// File: rtl/nes_palette_pkg.sv
// NES palette RAM shared definitions: default palette, FSM states,
// address mirroring and default-entry lookup.
package nes_palette_pkg;

  typedef enum logic {
    INIT,
    READY
  } pal_state_e;

  localparam logic [7:0] GREY_MASK = 8'h30;

  localparam logic [7:0] DEFAULT_PAL [32] = '{
    8'h0F, 8'h15, 8'h2C, 8'h12, 8'h30, 8'h27, 8'h1A, 8'h02,
    8'h0F, 8'h16, 8'h2A, 8'h11, 8'h0F, 8'h38, 8'h21, 8'h06,
    8'h0F, 8'h16, 8'h27, 8'h18, 8'h0F, 8'h1A, 8'h30, 8'h27,
    8'h0F, 8'h06, 8'h17, 8'h37, 8'h0F, 8'h36, 8'h16, 8'h10
  };

  function automatic logic [7:0] default_entry(
    input logic [31:0] k
  );
    logic [4:0] i;
    i = k[4:0];
    return (k < 32'd32) ? DEFAULT_PAL[i] : 8'h00;
  endfunction

  // Sprite backdrop slots 0x10/14/18/1C alias the
  // background backdrop slots.
  function automatic logic [31:0] mirror_addr(
    input logic [31:0] a
  );
    if (a[4] && a[1:0] == 2'b00)
      return {a[31:5], 1'b0, a[3:0]};
    return a;
  endfunction

endpackage

// File: rtl/nes_palette_rd_port.sv
// One palette read channel: mirroring, write-first bypass,
// optional greyscale mask (PALETTE_GREYSCALE_EN), output register.
// Ports: clk, rst, ready, rd_en, rd_addr, wr_fire, wr_maddr,
// wr_data, mem_word in; maddr, rd_data, rd_valid out.
module nes_palette_rd_port
  import nes_palette_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PALETTE_GREYSCALE_EN
  input  logic          greyscale,
`endif
  input  logic          ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_fire,
  input  logic [AW-1:0] wr_maddr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] maddr,
  input  logic [DW-1:0] mem_word,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] word;
  logic [DW-1:0] masked;

  assign maddr = AW'(mirror_addr(32'(rd_addr)));

  always_comb begin
    word = mem_word;
    if (wr_fire && wr_maddr == maddr)
      word = wr_data;
  end

  always_comb begin
    masked = word;
`ifdef PALETTE_GREYSCALE_EN
    if (greyscale)
      masked = word & DW'(GREY_MASK);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (ready && rd_en) begin
      rd_data  <= masked;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nes_palette_ram.sv
// NES palette RAM: default-load FSM, one storage array, NRD read
// channels. Optional greyscale input with PALETTE_GREYSCALE_EN.
// Ports: clk, rst, wr_en/wr_addr/wr_data, rd_en/rd_addr (packed
// per channel), rd_data/rd_valid (packed per channel), busy.
module nes_palette_ram
  import nes_palette_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PALETTE_GREYSCALE_EN
  input  logic              greyscale,
`endif
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_valid,
  output logic              busy
);

  pal_state_e    state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic          ready;
  logic          wr_fire;
  logic [AW-1:0] wr_maddr;

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      INIT: begin
        idx_n = idx + AW'(1);
        if (idx == '1)
          state_n = READY;
      end
      READY: ;
    endcase
  end

  assign busy     = (state == INIT);
  assign ready    = (state == READY);
  assign wr_fire  = ready && wr_en;
  assign wr_maddr = AW'(mirror_addr(32'(wr_addr)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[idx] <= DW'(default_entry(32'(idx)));
      else if (wr_en)
        mem[wr_maddr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] maddr;
    logic [DW-1:0] mem_word;

    assign mem_word = mem[maddr];

    nes_palette_rd_port #(
      .DW(DW),
      .AW(AW)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
`ifdef PALETTE_GREYSCALE_EN
      .greyscale(greyscale),
`endif
      .ready    (ready),
      .rd_en    (rd_en[g]),
      .rd_addr  (rd_addr[g*AW +: AW]),
      .wr_fire  (wr_fire),
      .wr_maddr (wr_maddr),
      .wr_data  (wr_data),
      .maddr    (maddr),
      .mem_word (mem_word),
      .rd_data  (rd_data[g*DW +: DW]),
      .rd_valid (rd_valid[g])
    );
  end

endmodule

// File: tb/tb_nes_palette_ram.sv
// Self-checking bench for nes_palette_ram: behavioural model
// compared every cycle plus directed literal checks.
module tb_nes_palette_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        busy;
`ifdef PALETTE_GREYSCALE_EN
  logic        greyscale = 1'b0;
`endif

  always #5 clk = ~clk;

  nes_palette_ram #(.DW(8), .AW(5), .NRD(2)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PALETTE_GREYSCALE_EN
    .greyscale(greyscale),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Bench's own copy of the power-up palette.
  byte unsigned pal [32] = '{
    8'h0F, 8'h15, 8'h2C, 8'h12, 8'h30, 8'h27, 8'h1A, 8'h02,
    8'h0F, 8'h16, 8'h2A, 8'h11, 8'h0F, 8'h38, 8'h21, 8'h06,
    8'h0F, 8'h16, 8'h27, 8'h18, 8'h0F, 8'h1A, 8'h30, 8'h27,
    8'h0F, 8'h06, 8'h17, 8'h37, 8'h0F, 8'h36, 8'h16, 8'h10
  };

  function automatic int mir(input int a);
    return (a >= 16 && a % 4 == 0) ? a - 16 : a;
  endfunction

  // Model: contents, remaining load cycles, expected outputs.
  byte unsigned m_mem [32];
  int           rem = 0;
  bit           known = 0;
  bit [1:0]     m_valid = '0;
  bit [15:0]    m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      known = 1;
      rem = 32;
      m_mem = pal;
      m_valid = '0;
      m_data = '0;
    end else if (known) begin
      if (rem > 0) begin
        rem--;
        m_valid = '0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (rd_en[c]) begin
            int a;
            int d;
            a = mir(int'(rd_addr[c*5 +: 5]));
            d = m_mem[a];
            if (wr_en && mir(int'(wr_addr)) == a)
              d = wr_data;
`ifdef PALETTE_GREYSCALE_EN
            if (greyscale)
              d = d % 64 - d % 16;
`endif
            m_data[c*8 +: 8] = 8'(d);
            m_valid[c] = 1'b1;
          end else begin
            m_valid[c] = 1'b0;
          end
        end
        if (wr_en)
          m_mem[mir(int'(wr_addr))] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (known) begin
      chk("busy", int'(busy), int'(rem != 0));
      chk("rd_valid", int'(rd_valid), int'(m_valid));
      chk("rd_data", int'(rd_data), int'(m_data));
    end
  end

  task automatic drive(
    input logic       we,
    input logic [4:0] wa,
    input logic [7:0] wd,
    input logic [1:0] re,
    input logic [4:0] a0,
    input logic [4:0] a1
  );
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 8'd0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts cycles with busy high; optionally pokes writes/reads.
  task automatic wait_ready(input bit poke, output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (poke)
        drive(1'b1, 5'h03, 8'h3F, 2'b11, 5'h03, 5'h03);
      else
        idle();
    end
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(1'b0, n);
    chk("busy_len_initial", n, 32);

    drive(1'b0, 5'd0, 8'd0, 2'b01, 5'h01, 5'd0);
    chk("read_01", int'(rd_data[7:0]), 'h15);
    chk("valid_01", int'(rd_valid), 'b01);
    drive(1'b0, 5'd0, 8'd0, 2'b01, 5'h1B, 5'd0);
    chk("read_1B", int'(rd_data[7:0]), 'h37);
    idle();
    chk("valid_idle", int'(rd_valid), 0);
    chk("hold_idle", int'(rd_data[7:0]), 'h37);

    drive(1'b1, 5'h10, 8'h22, 2'b00, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 8'd0, 2'b11, 5'h00, 5'h10);
    chk("mirror_ch0", int'(rd_data[7:0]), 'h22);
    chk("mirror_ch1", int'(rd_data[15:8]), 'h22);
    chk("mirror_valid", int'(rd_valid), 'b11);

    drive(1'b1, 5'h05, 8'h0F, 2'b10, 5'd0, 5'h05);
    chk("bypass_ch1", int'(rd_data[15:8]), 'h0F);
    chk("bypass_valid", int'(rd_valid), 'b10);

    drive(1'b1, 5'h04, 8'h2B, 2'b11, 5'h14, 5'h04);
    chk("bypass_mir_ch0", int'(rd_data[7:0]), 'h2B);
    chk("bypass_mir_ch1", int'(rd_data[15:8]), 'h2B);

    for (int i = 0; i < 32; i++)
      drive(1'b0, 5'd0, 8'd0, 2'b11, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++)
      drive(1'b1, 5'(i), 8'((i * 7 + 3) % 64),
            2'(i % 4), 5'((i * 5) % 32), 5'(i));
    idle();

    pulse_rst();
    wait_ready(1'b0, n);
    chk("busy_len_ready_rst", n, 32);
    drive(1'b0, 5'd0, 8'd0, 2'b11, 5'h04, 5'h1C);
    chk("reload_04", int'(rd_data[7:0]), 'h30);
    chk("reload_1C", int'(rd_data[15:8]), 'h0F);

    pulse_rst();
    repeat (10) idle();
    pulse_rst();
    wait_ready(1'b1, n);
    chk("busy_len_mid_init", n, 32);
    drive(1'b0, 5'd0, 8'd0, 2'b11, 5'h02, 5'h03);
    chk("mid_init_02", int'(rd_data[7:0]), 'h2C);
    chk("init_write_dropped", int'(rd_data[15:8]), 'h12);

`ifdef PALETTE_GREYSCALE_EN
    greyscale = 1'b1;
    drive(1'b0, 5'd0, 8'd0, 2'b01, 5'h05, 5'd0);
    greyscale = 1'b0;
    chk("grey_on", int'(rd_data[7:0]), 'h20);
    drive(1'b0, 5'd0, 8'd0, 2'b01, 5'h05, 5'd0);
    chk("grey_off", int'(rd_data[7:0]), 'h27);
`endif

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
